// File: rtl/ex_mem_stage_pkg.sv
// Shared MIPS datapath definitions: widths, ALU control codes, and the
// write-back/memory control bundle carried from EX into MEM.
package ex_mem_stage_pkg;

  localparam int DW = 32;
  localparam int RW = 5;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
  } wb_ctrl_t;

endpackage

// File: rtl/ex_mem_stage_branch_unit.sv
// Combinational beq/bne resolution and branch target computation for the
// instruction currently in EX.
module branch_unit
  import ex_mem_stage_pkg::*;
#(
  parameter int DW = ex_mem_stage_pkg::DW
) (
  input  logic [DW-1:0] pc_plus4,
  input  logic [DW-1:0] imm_sext,
  input  logic          alu_zero,
  input  logic          ex_valid,
  input  logic          ex_branch,
  input  logic          ex_branch_ne,
  output logic          taken_d,
  output logic [DW-1:0] target_d
);

  // bne inverts the sense of the zero flag; the target wraps modulo 2^DW
  assign taken_d  = ex_valid & ex_branch & (alu_zero ^ ex_branch_ne);
  assign target_d = pc_plus4 + (imm_sext << 2);

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with branch resolution, forwarding-hit detection
// and load-use hazard detection for the execute-stage operand muxes.
module ex_mem_stage
  import ex_mem_stage_pkg::*;
#(
  parameter int DW = ex_mem_stage_pkg::DW,
  parameter int RW = ex_mem_stage_pkg::RW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] alu_result,
  input  logic          alu_zero,
  input  logic [DW-1:0] store_data,
  input  logic [DW-1:0] pc_plus4,
  input  logic [DW-1:0] imm_sext,
  input  logic          ex_valid,
  input  logic          ex_reg_write,
  input  logic          ex_mem_read,
  input  logic          ex_mem_write,
  input  logic          ex_mem_to_reg,
  input  logic          ex_branch,
  input  logic          ex_branch_ne,
  input  logic [RW-1:0] ex_write_reg,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic          stall,
  input  logic          flush,
  output logic          mem_valid,
  output logic [DW-1:0] mem_alu_result,
  output logic [DW-1:0] mem_store_data,
  output logic          mem_reg_write,
  output logic          mem_mem_read,
  output logic          mem_mem_write,
  output logic          mem_mem_to_reg,
  output logic [RW-1:0] mem_write_reg,
  output logic          branch_taken,
  output logic [DW-1:0] branch_target,
  output logic          fwd_hit_a,
  output logic          fwd_hit_b,
  output logic          load_use_stall
);

  logic          taken_d;
  logic [DW-1:0] target_d;
  wb_ctrl_t      ex_ctrl;
  wb_ctrl_t      mem_ctrl;
  logic          dest_live;

  branch_unit #(.DW(DW)) u_branch (
    .pc_plus4     (pc_plus4),
    .imm_sext     (imm_sext),
    .alu_zero     (alu_zero),
    .ex_valid     (ex_valid),
    .ex_branch    (ex_branch),
    .ex_branch_ne (ex_branch_ne),
    .taken_d      (taken_d),
    .target_d     (target_d)
  );

  assign ex_ctrl = '{reg_write:  ex_reg_write,
                     mem_read:   ex_mem_read,
                     mem_write:  ex_mem_write,
                     mem_to_reg: ex_mem_to_reg};

  // Flush clears only valid/control state; data registers keep stale values
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_valid      <= 1'b0;
      mem_ctrl       <= '0;
      mem_alu_result <= '0;
      mem_store_data <= '0;
      mem_write_reg  <= '0;
      branch_taken   <= 1'b0;
      branch_target  <= '0;
    end else if (flush) begin
      mem_valid    <= 1'b0;
      mem_ctrl     <= '0;
      branch_taken <= 1'b0;
    end else if (!stall) begin
      mem_valid      <= ex_valid;
      mem_ctrl       <= ex_ctrl;
      mem_alu_result <= alu_result;
      mem_store_data <= store_data;
      mem_write_reg  <= ex_write_reg;
      branch_taken   <= taken_d;
      branch_target  <= target_d;
    end
  end

  assign mem_reg_write  = mem_ctrl.reg_write;
  assign mem_mem_read   = mem_ctrl.mem_read;
  assign mem_mem_write  = mem_ctrl.mem_write;
  assign mem_mem_to_reg = mem_ctrl.mem_to_reg;

  // Hazard outputs see only registered state, never the ALU inputs
  assign dest_live      = mem_valid & (mem_write_reg != RW'(REG_ZERO));
  assign fwd_hit_a      = dest_live & mem_ctrl.reg_write & (mem_write_reg == id_rs);
  assign fwd_hit_b      = dest_live & mem_ctrl.reg_write & (mem_write_reg == id_rt);
  assign load_use_stall = dest_live & mem_ctrl.mem_read &
                          ((mem_write_reg == id_rs) | (mem_write_reg == id_rt));

  a_rd_wr_exclusive : assert property (@(posedge clk) disable iff (!rst_n)
    !(ex_valid && ex_mem_read && ex_mem_write));

endmodule
